triwave_generator: RTL and testbench

- Produces a 6-bit triangle-wave duty value that ramps 0→63→0 continuously.
- Step rate is set by a programmable prescaler (Scale).
- Run/freeze is gated by the switch input Enable_SW_2.
- Output feeds a downstream PWM stage as its duty-cycle word, e.g. for a breathing LED.

---
 rtl/triwave_pkg.sv | 13 +
 rtl/triwave_prescaler.sv | 33 +++
 rtl/triwave_generator.sv | 66 ++++++
 tb/tb_triwave_generator.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/triwave_pkg.sv
// Shared types and constants for the triangle-wave duty generator.
package triwave_pkg;

  localparam int TRI_WIDTH = 6;
  localparam int DUTY_MAX  = (1 << TRI_WIDTH) - 1;
  localparam int DUTY_MIN  = 0;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_t;

endpackage

// File: rtl/triwave_prescaler.sv
// Step-rate prescaler: issues one tick every Scale+1 enabled sysclk cycles.
module triwave_prescaler
  import triwave_pkg::*;
#(
  parameter int WIDTH = TRI_WIDTH
) (
  input  logic             sysclk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] Scale,
  output logic             tick
);

  logic [WIDTH-1:0] r_cnt;
  logic             w_terminal;

  // >= rather than == so a Scale lowered below the running count fires at once
  assign w_terminal = (r_cnt >= Scale);
  assign tick       = en && w_terminal;

  always_ff @(posedge sysclk) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (en) begin
      if (w_terminal) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/triwave_generator.sv
// Triangle-wave duty word (0..max..0) for a downstream PWM stage.
//   state    | meaning
//   DIR_UP   | duty climbing; at max turns to max-1 and DIR_DOWN
//   DIR_DOWN | duty falling; at 0 turns to 1 and DIR_UP
module triwave_generator
  import triwave_pkg::*;
#(
  parameter int WIDTH = TRI_WIDTH
) (
  input  logic             sysclk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] Scale,
  input  logic             Enable_SW_2,
  output logic [WIDTH-1:0] Duty_Output
);

  localparam logic [WIDTH-1:0] LP_DUTY_MAX = WIDTH'((1 << WIDTH) - 1);
  localparam logic [WIDTH-1:0] LP_DUTY_MIN = WIDTH'(DUTY_MIN);

  logic             w_tick;
  logic [WIDTH-1:0] r_duty;
  dir_t             r_dir;

  triwave_prescaler #(
    .WIDTH (WIDTH)
  ) u_prescaler (
    .sysclk (sysclk),
    .rst_n  (rst_n),
    .en     (Enable_SW_2),
    .Scale  (Scale),
    .tick   (w_tick)
  );

  always_ff @(posedge sysclk) begin
    if (!rst_n) begin
      r_duty <= LP_DUTY_MIN;
      r_dir  <= DIR_UP;
    end else if (w_tick) begin
      case (r_dir)
        DIR_UP: begin
          if (r_duty == LP_DUTY_MAX) begin
            r_duty <= LP_DUTY_MAX - 1'b1;
            r_dir  <= DIR_DOWN;
          end else begin
            r_duty <= r_duty + 1'b1;
          end
        end
        DIR_DOWN: begin
          if (r_duty == LP_DUTY_MIN) begin
            r_duty <= LP_DUTY_MIN + 1'b1;
            r_dir  <= DIR_UP;
          end else begin
            r_duty <= r_duty - 1'b1;
          end
        end
        default: begin
          r_duty <= LP_DUTY_MIN;
          r_dir  <= DIR_UP;
        end
      endcase
    end
  end

  assign Duty_Output = r_duty;

endmodule

// File: tb/tb_triwave_generator.sv
// Directed self-checking bench for triwave_generator.
module tb_triwave_generator;

  logic       sysclk;
  logic       rst_n;
  logic [5:0] Scale;
  logic       Enable_SW_2;
  logic [5:0] Duty_Output;

  int n_tests = 0;
  int n_fail  = 0;

  triwave_generator #(.WIDTH(6)) dut (
    .sysclk      (sysclk),
    .rst_n       (rst_n),
    .Scale       (Scale),
    .Enable_SW_2 (Enable_SW_2),
    .Duty_Output (Duty_Output)
  );

  initial sysclk = 1'b0;
  always #10 sysclk = ~sysclk;

  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // advance n rising edges, then settle 1 time unit past the last one
  task automatic cyc(input int n);
    repeat (n) @(posedge sysclk);
    #1;
  endtask

  // ideal triangle value after a given number of steps from 0/UP
  function automatic int tri_ref(input int steps);
    int p;
    p = steps % 126;
    return (p <= 63) ? p : 126 - p;
  endfunction

  task automatic do_reset(input logic [5:0] sc);
    rst_n       = 1'b0;
    Enable_SW_2 = 1'b1;
    Scale       = sc;
    cyc(1);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n       = 1'b0;
    Enable_SW_2 = 1'b1;
    Scale       = 6'd12;

    // reset held 3 cycles with enable high
    cyc(3);
    chk("reset_duty", Duty_Output, 0);
    rst_n = 1'b1;

    // Scale=12 long run: a step every 13 cycles, period 1638
    for (int k = 1; k <= 25000; k++) begin
      cyc(1);
      chk("ramp_s12", Duty_Output, tri_ref(k / 13));
      if (k == 12)   chk("first_step_pre", Duty_Output, 0);
      if (k == 13)   chk("first_step", Duty_Output, 1);
      if (k == 26)   chk("second_step", Duty_Output, 2);
      if (k == 818)  chk("up_turn_62", Duty_Output, 62);
      if (k == 819)  chk("peak_start", Duty_Output, 63);
      if (k == 831)  chk("peak_end", Duty_Output, 63);
      if (k == 832)  chk("after_peak", Duty_Output, 62);
      if (k == 1625) chk("down_turn_1", Duty_Output, 1);
      if (k == 1638) chk("floor_start", Duty_Output, 0);
      if (k == 1650) chk("floor_end", Duty_Output, 0);
      if (k == 1651) chk("after_floor", Duty_Output, 1);
      if (k == 1638 + 819) chk("peak_period2", Duty_Output, 63);
    end

    // Scale=0: a step on every cycle, period 126
    do_reset(6'd0);
    chk("s0_reset", Duty_Output, 0);
    for (int k = 1; k <= 260; k++) begin
      cyc(1);
      chk("ramp_s0", Duty_Output, tri_ref(k));
    end

    // Scale lowered 12 -> 3 while cnt=10: step on the next edge, then every 4
    do_reset(6'd12);
    cyc(13);
    chk("sw_base", Duty_Output, 1);
    cyc(10);
    chk("sw_cnt10", Duty_Output, 1);
    Scale = 6'd3;
    cyc(1);
    chk("sw_immediate", Duty_Output, 2);
    cyc(3);
    chk("sw_hold3", Duty_Output, 2);
    cyc(1);
    chk("sw_step4", Duty_Output, 3);
    cyc(4);
    chk("sw_step8", Duty_Output, 4);

    // freeze at 40 on the UP ramp with 5 counts already consumed
    do_reset(6'd12);
    cyc(40 * 13);
    chk("frz_at40", Duty_Output, 40);
    cyc(5);
    Enable_SW_2 = 1'b0;
    for (int k = 0; k < 100; k++) begin
      cyc(1);
      chk("frz_hold", Duty_Output, 40);
    end
    Enable_SW_2 = 1'b1;
    cyc(7);
    chk("frz_resume_pre", Duty_Output, 40);
    cyc(1);
    chk("frz_resume_41", Duty_Output, 41);
    cyc(13);
    chk("frz_resume_42", Duty_Output, 42);

    // reset during the DOWN ramp at duty=30
    do_reset(6'd0);
    cyc(96);
    chk("mid_down30", Duty_Output, 30);
    cyc(1);
    chk("mid_down29", Duty_Output, 29);
    rst_n = 1'b0;
    cyc(1);
    chk("mid_rst_zero", Duty_Output, 0);
    rst_n = 1'b1;
    cyc(1);
    chk("mid_rst_up1", Duty_Output, 1);
    cyc(1);
    chk("mid_rst_up2", Duty_Output, 2);

    // reset wins over enable while held
    rst_n = 1'b0;
    cyc(2);
    chk("rst_priority", Duty_Output, 0);
    rst_n = 1'b1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
